video_demod: RTL and testbench
==============================

Name: video_demod

Overview:
Parametrised luma demodulator for the tape-data path. Consumes the 8-bit ITU-656 word stream from the TV decoder and tracks SAV/EAV timing so that only active-video luma is used. Averages OVERSAMPLE consecutive luma words, slices the average into one of NUM_SYMBOLS data levels or two framing markers, and emits framed symbols to the downstream deframer with a one-cycle valid strobe.

Parameters:
OVERSAMPLE, 4, luma words averaged per symbol; power of two, 1..16.
SYMBOL_BITS, 4, width of data_out.
NUM_SYMBOLS, 12, data levels; level NUM_SYMBOLS is BEGIN, level NUM_SYMBOLS+1 is END.
LEVEL_BASE, 65, lower edge of level 0 (8-bit luma code).
LEVEL_STEP, 10, width of each level bin.

Ports:
clkin  in  1  decoder pixel clock (27 MHz); all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
td_in  in  8  ITU-656 word stream, Cb Y Cr Y ordering.
data_out  out  SYMBOL_BITS  decoded symbol; valid only while data_valid=1.
data_valid  out  1  one-cycle strobe per decoded data symbol inside a frame.
frame_active  out  1  high between an accepted BEGIN marker and END/abort.
frame_done  out  1  one-cycle pulse when END is accepted in a frame.
sym_err  out  1  one-cycle pulse when an average falls outside every bin.
line_active  out  1  high while inside active video (after SAV with V=0, until EAV).

Behaviour:
- Reset: every output 0; parser in HUNT; accumulator, sample counter and word phase cleared; frame FSM in WAIT_BEGIN.
- Timing parser states: HUNT -> P1 on 0xFF -> P2 on 0x00 -> P3 on 0x00 -> XY on the next word. Any other word in P1..P3 returns to HUNT; 0xFF in P1..P3 returns to P1. A 0xFF in any state starts a new preamble and overrides data handling.
- XY decode: bit4 H (0=SAV, 1=EAV), bit5 V. SAV with V=0 sets line_active the following cycle. SAV with V=1, or any EAV, clears line_active.
- Word phase: on SAV the first word is chroma. Phase toggles every word; odd words are luma. Preamble and XY words are never sampled.
- Accumulator width 8+log2(OVERSAMPLE). Each luma word adds td_in. On the OVERSAMPLE-th word, avg = sum >> log2(OVERSAMPLE) (truncating) is registered, and the accumulator and counter clear.
- EAV, blanking SAV or a new preamble with a partial group: the partial sum is discarded and no symbol is produced. Groups never span lines.
- Slicer: k = (avg - LEVEL_BASE) / LEVEL_STEP when avg >= LEVEL_BASE. Bins are half-open [BASE+k*STEP, BASE+(k+1)*STEP). If avg < BASE or k > NUM_SYMBOLS+1, pulse sym_err and emit no symbol.
- Data level k < NUM_SYMBOLS maps through the package table SYMBOL_MAP. Defaults: 0000,0001,0011,0111,1111,1110,1100,1000,1001,0110,1010,0101.
- Frame FSM:
  - WAIT_BEGIN + BEGIN -> IN_FRAME, frame_active=1.
  - WAIT_BEGIN + data or END -> ignored.
  - IN_FRAME + data -> data_valid=1 with data_out.
  - IN_FRAME + END -> WAIT_BEGIN, frame_done=1, frame_active=0.
  - IN_FRAME + BEGIN -> stays IN_FRAME (restart, no pulse).
- sym_err does not change frame state.
- Latency: data_valid, frame_done and sym_err assert exactly 2 clkin cycles after the rising edge that samples the last luma word of a group (1 cycle average register, 1 cycle slice/FSM).
- data_out holds its last valid value between strobes.
- Reset mid-operation aborts the frame immediately, with all outputs at reset values.

Decomposition:
- Package video_pkg holds:
  - constants PREAMBLE_FF and PREAMBLE_00;
  - XY_H_BIT=4 and XY_V_BIT=5;
  - the SYMBOL_MAP array;
  - the frame-state enum (WAIT_BEGIN, IN_FRAME);
  - the parser-state enum (HUNT, P1, P2, P3, XY).
- Sub-module luma_slicer (registered avg -> level index, marker flags, out-of-range flag) is instantiated once.

Test Plan:
- Defaults, after SAV FF 00 00 80: four luma words of 190 (BEGIN), then four luma words each of 70, 70, 70 and 74 (sum 284, avg 71) -> frame_active=1, one data_valid with data_out=0000, 2 cycles after the last luma word.
- In frame, luma 4x180 then 4x200 (END) -> data_valid with 0101, then frame_done pulse, frame_active=0. A following 4x100 produces no data_valid.
- In frame, 2 luma words of 100 then EAV FF 00 00 9D -> no strobe. After the next SAV, 4x100 -> data_out=0111, and the stale partial sum is not included.
- In frame, 4x50 and separately 4x210 -> one sym_err pulse each, no data_valid, frame_active stays 1.
- SAV FF 00 00 AB (V=1) followed by 4x190 -> line_active=0, no frame entry, no strobes.
- Assert reset_n=0 mid-group while IN_FRAME -> all outputs 0 asynchronously. After release, 4x70 without SAV/BEGIN -> no data_valid.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, symbol table and state types for the ITU-656 luma demodulator.
`default_nettype none

package video_pkg;

  localparam logic [7:0] PREAMBLE_FF = 8'hFF;
  localparam logic [7:0] PREAMBLE_00 = 8'h00;

  localparam int XY_H_BIT = 4;
  localparam int XY_V_BIT = 5;

  localparam int SYM_W     = 4;
  localparam int MAP_DEPTH = 16;

  // Entries past the last data level are never selected; they only pad the table.
  localparam logic [SYM_W-1:0] SYMBOL_MAP [MAP_DEPTH] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0111,
    4'b1111, 4'b1110, 4'b1100, 4'b1000,
    4'b1001, 4'b0110, 4'b1010, 4'b0101,
    4'b0000, 4'b0000, 4'b0000, 4'b0000
  };

  typedef enum logic {
    WAIT_BEGIN = 1'b0,
    IN_FRAME   = 1'b1
  } frame_state_t;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    XY   = 3'd4
  } parse_state_t;

endpackage

`default_nettype wire

// File: rtl/luma_slicer.sv
// Registered slicer: maps an averaged luma code onto a level bin and classifies it.
`default_nettype none

module luma_slicer #(
  parameter int NUM_SYMBOLS = 12,
  parameter int LEVEL_BASE  = 65,
  parameter int LEVEL_STEP  = 10,
  parameter int LVL_W       = 4
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             i_vld,
  input  logic [7:0]       i_avg,
  output logic [LVL_W-1:0] o_level,
  output logic             o_data,
  output logic             o_begin,
  output logic             o_end,
  output logic             o_err
);

  logic             w_hit;
  logic [LVL_W-1:0] w_level;

  // Half-open bins [BASE+k*STEP, BASE+(k+1)*STEP) for every data level plus the two markers.
  always_comb begin
    w_hit   = 1'b0;
    w_level = '0;
    for (int i = 0; i < NUM_SYMBOLS + 2; i++) begin
      if ((int'(i_avg) >= LEVEL_BASE + i * LEVEL_STEP) &&
          (int'(i_avg) <  LEVEL_BASE + (i + 1) * LEVEL_STEP)) begin
        w_hit   = 1'b1;
        w_level = LVL_W'(i);
      end
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      o_level <= '0;
      o_data  <= 1'b0;
      o_begin <= 1'b0;
      o_end   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_level <= w_level;
      o_data  <= i_vld && w_hit && (w_level <  LVL_W'(NUM_SYMBOLS));
      o_begin <= i_vld && w_hit && (w_level == LVL_W'(NUM_SYMBOLS));
      o_end   <= i_vld && w_hit && (w_level == LVL_W'(NUM_SYMBOLS + 1));
      o_err   <= i_vld && !w_hit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_demod.sv
// ITU-656 luma demodulator: SAV/EAV tracking, luma group averaging, slicing and symbol framing.
`default_nettype none

module video_demod
  import video_pkg::*;
#(
  parameter int OVERSAMPLE  = 4,
  parameter int SYMBOL_BITS = 4,
  parameter int NUM_SYMBOLS = 12,
  parameter int LEVEL_BASE  = 65,
  parameter int LEVEL_STEP  = 10
) (
  input  logic                   clkin,
  input  logic                   reset_n,
  input  logic [7:0]             td_in,
  output logic [SYMBOL_BITS-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_active,
  output logic                   frame_done,
  output logic                   sym_err,
  output logic                   line_active
);

  localparam int OS_LOG2 = $clog2(OVERSAMPLE);
  localparam int ACC_W   = 8 + OS_LOG2;
  localparam int CNT_W   = (OS_LOG2 > 0) ? OS_LOG2 : 1;
  localparam int LVL_W   = $clog2(NUM_SYMBOLS + 2);

  parse_state_t r_pstate, w_pnext;
  logic         w_is_ff;
  logic         w_xy_word;
  logic         w_data_word;
  logic         r_line_active;

  // ---------------- timing reference parser ----------------
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) r_pstate <= HUNT;
    else          r_pstate <= w_pnext;
  end

  always_comb begin
    w_pnext = r_pstate;
    if (td_in == PREAMBLE_FF) begin
      w_pnext = P1;
    end else begin
      case (r_pstate)
        P1:      w_pnext = (td_in == PREAMBLE_00) ? P2 : HUNT;
        P2:      w_pnext = (td_in == PREAMBLE_00) ? P3 : HUNT;
        P3:      w_pnext = XY;
        XY:      w_pnext = HUNT;
        default: w_pnext = HUNT;
      endcase
    end
  end

  always_comb begin
    w_is_ff     = (td_in == PREAMBLE_FF);
    w_xy_word   = (r_pstate == P3) && !w_is_ff;
    w_data_word = r_line_active && !w_is_ff &&
                  ((r_pstate == HUNT) || (r_pstate == XY));
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n)       r_line_active <= 1'b0;
    else if (w_xy_word) r_line_active <= !td_in[XY_H_BIT] && !td_in[XY_V_BIT];
  end

  // ---------------- luma accumulation ----------------
  logic             r_phase;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_avg;
  logic             r_avg_vld;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_avg;

  assign w_sum = r_acc + ACC_W'(td_in);
  assign w_avg = 8'(w_sum >> OS_LOG2);

  // Any preamble or XY word drops a partial group so that groups never straddle lines.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_phase   <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (w_is_ff || w_xy_word) begin
        r_phase <= 1'b0;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_data_word) begin
        r_phase <= !r_phase;
        if (r_phase) begin
          if (r_cnt == CNT_W'(OVERSAMPLE - 1)) begin
            r_avg     <= w_avg;
            r_avg_vld <= 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // ---------------- slicer ----------------
  logic [LVL_W-1:0] w_sl_level;
  logic             w_sl_data;
  logic             w_sl_begin;
  logic             w_sl_end;
  logic             w_sl_err;

  luma_slicer #(
    .NUM_SYMBOLS (NUM_SYMBOLS),
    .LEVEL_BASE  (LEVEL_BASE),
    .LEVEL_STEP  (LEVEL_STEP),
    .LVL_W       (LVL_W)
  ) u_slicer (
    .clkin   (clkin),
    .reset_n (reset_n),
    .i_vld   (r_avg_vld),
    .i_avg   (r_avg),
    .o_level (w_sl_level),
    .o_data  (w_sl_data),
    .o_begin (w_sl_begin),
    .o_end   (w_sl_end),
    .o_err   (w_sl_err)
  );

  // ---------------- frame FSM ----------------
  frame_state_t           r_fstate, w_fnext;
  logic                   w_dv;
  logic                   w_fd;
  logic                   w_err;
  logic [SYMBOL_BITS-1:0] w_sym;
  logic [3:0]             w_map_idx;
  logic                   r_dv;
  logic                   r_fd;
  logic                   r_err;
  logic [SYMBOL_BITS-1:0] r_data_out;

  assign w_map_idx = 4'(w_sl_level);

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) r_fstate <= WAIT_BEGIN;
    else          r_fstate <= w_fnext;
  end

  always_comb begin
    w_fnext = r_fstate;
    case (r_fstate)
      WAIT_BEGIN: if (w_sl_begin) w_fnext = IN_FRAME;
      IN_FRAME:   if (w_sl_end)   w_fnext = WAIT_BEGIN;
      default:    w_fnext = WAIT_BEGIN;
    endcase
  end

  always_comb begin
    w_dv  = w_sl_data && (r_fstate == IN_FRAME);
    w_fd  = w_sl_end  && (r_fstate == IN_FRAME);
    w_err = w_sl_err;
    w_sym = SYMBOL_BITS'(SYMBOL_MAP[w_map_idx]);
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_dv       <= 1'b0;
      r_fd       <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_dv  <= w_dv;
      r_fd  <= w_fd;
      r_err <= w_err;
      if (w_dv) r_data_out <= w_sym;
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_dv;
  assign frame_done   = r_fd;
  assign sym_err      = r_err;
  assign frame_active = (r_fstate == IN_FRAME);
  assign line_active  = r_line_active;

endmodule

`default_nettype wire

// File: tb/tb_video_demod.sv
// Directed bench for video_demod with a word-level reference model and per-cycle compare.
`default_nettype none

module tb_video_demod;

  localparam int OS   = 4;
  localparam int BASE = 65;
  localparam int STEP = 10;
  localparam int NSYM = 12;

  logic       clkin = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] td_in = 8'h10;
  logic [3:0] data_out;
  logic       data_valid, frame_active, frame_done, sym_err, line_active;

  video_demod #(
    .OVERSAMPLE (OS), .SYMBOL_BITS (4), .NUM_SYMBOLS (NSYM),
    .LEVEL_BASE (BASE), .LEVEL_STEP (STEP)
  ) dut (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .td_in        (td_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .sym_err      (sym_err),
    .line_active  (line_active)
  );

  always #5 clkin = ~clkin;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_dv = 0, cnt_fd = 0, cnt_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] MAP [NSYM] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE,
                             4'hC, 4'h8, 4'h9, 4'h6, 4'hA, 4'h5};
  int         cyc = 0;
  logic [7:0] h0 = 8'h00, h1 = 8'h00, h2 = 8'h00;
  bit         m_line = 0, m_frame = 0;
  int         m_idx = 0, m_sum = 0, m_cnt = 0;
  int         q_due[$];
  int         q_avg[$];
  logic       e_dv = 0, e_fd = 0, e_err = 0;
  logic [3:0] e_dout = 4'h0;

  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
      m_line = 0; m_frame = 0; m_idx = 0; m_sum = 0; m_cnt = 0;
      q_due.delete(); q_avg.delete();
      e_dv = 0; e_fd = 0; e_err = 0; e_dout = 4'h0;
    end else begin
      int a, k;
      logic [7:0] w;
      cyc++;
      e_dv = 0; e_fd = 0; e_err = 0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        a = q_avg.pop_front();
        void'(q_due.pop_front());
        if (a < BASE) e_err = 1;
        else begin
          k = (a - BASE) / STEP;
          if (k > NSYM + 1) e_err = 1;
          else if (k == NSYM) m_frame = 1;
          else if (k == NSYM + 1) begin
            if (m_frame) e_fd = 1;
            m_frame = 0;
          end else if (m_frame) begin
            e_dv = 1;
            e_dout = MAP[k];
          end
        end
      end
      w = td_in;
      if (w == 8'hFF) begin
        m_sum = 0; m_cnt = 0;
      end else if (h2 == 8'hFF && h1 == 8'h00 && h0 == 8'h00) begin
        m_line = (w[5:4] == 2'b00);
        m_sum = 0; m_cnt = 0; m_idx = 0;
      end else if ((h0 == 8'hFF && w == 8'h00) ||
                   (h1 == 8'hFF && h0 == 8'h00 && w == 8'h00)) begin
        m_idx = m_idx;
      end else if (m_line) begin
        if (m_idx % 2 == 1) begin
          m_sum += int'(w);
          m_cnt++;
          if (m_cnt == OS) begin
            q_due.push_back(cyc + 2);
            q_avg.push_back(m_sum / OS);
            m_sum = 0; m_cnt = 0;
          end
        end
        m_idx++;
      end
      h2 = h1; h1 = h0; h0 = w;
    end
  end

  always @(negedge clkin) begin
    chk("data_valid",   int'(data_valid),   int'(e_dv));
    chk("frame_done",   int'(frame_done),   int'(e_fd));
    chk("sym_err",      int'(sym_err),      int'(e_err));
    chk("frame_active", int'(frame_active), int'(m_frame));
    chk("line_active",  int'(line_active),  int'(m_line));
    chk("data_out",     int'(data_out),     int'(e_dout));
    if (data_valid) cnt_dv++;
    if (frame_done) cnt_fd++;
    if (sym_err)    cnt_err++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] w);
    @(negedge clkin);
    td_in = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h10);
  endtask

  task automatic sav(input logic [7:0] xy);
    send(8'hFF); send(8'h00); send(8'h00); send(xy);
  endtask

  task automatic lumas(input logic [7:0] y, input int n);
    for (int i = 0; i < n; i++) begin
      send(8'h80);
      send(y);
    end
  endtask

  // EAV right after the last luma word: strobes must be quiet one edge later and fire two edges later.
  task automatic eav_check(input string tag, input logic [2:0] exp3, input logic [3:0] exp_dout);
    send(8'hFF);
    send(8'h00);
    chk({tag, "_early"}, int'({data_valid, frame_done, sym_err}), 0);
    send(8'h00);
    chk({tag, "_strobe"}, int'({data_valid, frame_done, sym_err}), int'(exp3));
    chk({tag, "_dout"}, int'(data_out), int'(exp_dout));
    send(8'h9D);
    idle(4);
  endtask

  initial begin
    repeat (3) @(posedge clkin);
    #1;
    chk("reset_outputs", int'({data_out, data_valid, frame_active, frame_done, sym_err, line_active}), 0);
    @(negedge clkin);
    reset_n = 1'b1;
    idle(4);

    // Blanking SAV: nothing is sampled
    sav(8'hAB);
    lumas(8'd190, 4);
    chk("vblank_line", int'(line_active), 0);
    eav_check("vblank", 3'b000, 4'h0);
    chk("vblank_frame", int'(frame_active), 0);

    // BEGIN then avg 71 -> level 0
    sav(8'h80);
    lumas(8'd190, 4);
    lumas(8'd70, 3);
    lumas(8'd74, 1);
    chk("line_on", int'(line_active), 1);
    eav_check("first", 3'b100, 4'b0000);
    chk("frame_on", int'(frame_active), 1);
    chk("dv_count1", cnt_dv, 1);

    // level 11 then END, then data outside a frame
    sav(8'h80);
    lumas(8'd180, 4);
    lumas(8'd200, 4);
    eav_check("end", 3'b010, 4'b0101);
    chk("frame_off", int'(frame_active), 0);
    sav(8'h80);
    lumas(8'd100, 4);
    eav_check("outside", 3'b000, 4'b0101);

    // partial group dropped at EAV
    sav(8'h80);
    lumas(8'd190, 4);
    lumas(8'd200, 2);
    eav_check("partial", 3'b000, 4'b0101);
    sav(8'h80);
    lumas(8'd100, 4);
    eav_check("fresh", 3'b100, 4'b0111);

    // out-of-range averages
    sav(8'h80);
    lumas(8'd50, 4);
    lumas(8'd210, 4);
    eav_check("range", 3'b001, 4'b0111);
    chk("frame_kept", int'(frame_active), 1);
    chk("err_count", cnt_err, 2);

    // reset in the middle of a group
    sav(8'h80);
    lumas(8'd70, 2);
    chk("pre_reset_active", int'({frame_active, line_active}), 3);
    @(posedge clkin);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", int'({data_out, data_valid, frame_active, frame_done, sym_err, line_active}), 0);
    repeat (3) @(negedge clkin);
    reset_n = 1'b1;
    lumas(8'd70, 4);
    idle(6);
    chk("dv_total", cnt_dv, 3);
    chk("fd_total", cnt_fd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
